// File: rtl/rc4_prga_engine.sv
// rtl/rc4_prga_engine.sv - RC4 PRGA engine: XORs keystream with ciphertext ROM into result RAM
module rc4_prga_engine #(
   parameter int MSG_LEN  = 32,
   parameter int CHECK_EN = 1,
   localparam int KADDR_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               key_ok,
   output logic [7:0]         s_addr,
   output logic [7:0]         s_wdata,
   output logic               s_wren,
   input  logic [7:0]         s_rdata,
   output logic [KADDR_W-1:0] rom_addr,
   input  logic [7:0]         rom_rdata,
   output logic [KADDR_W-1:0] res_addr,
   output logic [7:0]         res_wdata,
   output logic               res_wren
);

   typedef enum logic [3:0] {
      IDLE, RD_I, WT_I, CALC_J, RD_J, WT_J, WR_J, WR_I, RD_F, WT_F, OUT, NEXT, DONE
   } state_t;

   localparam logic [KADDR_W-1:0] K_LAST = KADDR_W'(MSG_LEN - 1);

   state_t             state_q, state_d;
   logic [7:0]         i_q, i_d, j_q, j_d;
   logic [7:0]         si_q, si_d, sj_q, sj_d, f_q, f_d;
   logic [KADDR_W-1:0] k_q, k_d;
   logic               key_ok_q, key_ok_d;
   logic [7:0]         pt;
   logic               pt_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         i_q      <= 8'd0;
         j_q      <= 8'd0;
         si_q     <= 8'd0;
         sj_q     <= 8'd0;
         f_q      <= 8'd0;
         k_q      <= '0;
         key_ok_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         si_q     <= si_d;
         sj_q     <= sj_d;
         f_q      <= f_d;
         k_q      <= k_d;
         key_ok_q <= key_ok_d;
      end
   end

   // Plaintext screen accepts lowercase letters and space only
   assign pt    = f_q ^ rom_rdata;
   assign pt_ok = ((pt >= 8'h61) && (pt <= 8'h7A)) || (pt == 8'h20);

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      si_d      = si_q;
      sj_d      = sj_q;
      f_d       = f_q;
      k_d       = k_q;
      key_ok_d  = key_ok_q;
      s_addr    = i_q;
      s_wdata   = 8'd0;
      s_wren    = 1'b0;
      res_wdata = 8'd0;
      res_wren  = 1'b0;
      done      = 1'b0;
      busy      = (state_q != IDLE) && (state_q != DONE);
      case (state_q)
         IDLE: begin
            if (start) begin
               i_d      = 8'd1;
               j_d      = 8'd0;
               k_d      = '0;
               key_ok_d = 1'b1;
               state_d  = RD_I;
            end
         end
         RD_I:   state_d = WT_I;
         WT_I: begin
            si_d    = s_rdata;
            state_d = CALC_J;
         end
         CALC_J: begin
            j_d     = j_q + si_q;
            state_d = RD_J;
         end
         RD_J: begin
            s_addr  = j_q;
            state_d = WT_J;
         end
         WT_J: begin
            s_addr  = j_q;
            sj_d    = s_rdata;
            state_d = WR_J;
         end
         WR_J: begin
            s_addr  = j_q;
            s_wdata = si_q;
            s_wren  = 1'b1;
            state_d = WR_I;
         end
         WR_I: begin
            s_addr  = i_q;
            s_wdata = sj_q;
            s_wren  = 1'b1;
            state_d = RD_F;
         end
         RD_F: begin
            s_addr  = si_q + sj_q;
            state_d = WT_F;
         end
         WT_F: begin
            s_addr  = si_q + sj_q;
            f_d     = s_rdata;
            state_d = OUT;
         end
         OUT: begin
            res_wdata = pt;
            res_wren  = 1'b1;
            if ((CHECK_EN != 0) && !pt_ok) key_ok_d = 1'b0;
            state_d = NEXT;
         end
         NEXT: begin
            if (!key_ok_q || (k_q == K_LAST)) begin
               state_d = DONE;
            end else begin
               k_d     = k_q + 1'b1;
               i_d     = i_q + 8'd1;
               state_d = RD_I;
            end
         end
         DONE: begin
            done = 1'b1;
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign key_ok   = key_ok_q;
   assign rom_addr = k_q;
   assign res_addr = k_q;

endmodule

// File: tb/tb_rc4_prga_engine.sv
// tb/tb_rc4_prga_engine.sv - scoreboard bench for rc4_prga_engine over three parameter sets
module tb_rc4_prga_engine;

   logic       clk;
   logic       rst_n;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   logic       start  [3];
   logic       ld     [3];
   logic       busy   [3];
   logic       done   [3];
   logic       key_ok [3];
   logic       s_wren [3];
   logic [7:0] s_img  [3][256];
   logic [7:0] rom_img[3][300];
   int         exp_q  [3][$];

   logic [7:0] ms [256];
   logic [7:0] ks [300];
   logic [7:0] key_b [3];
   logic [7:0] ptxt  [9];
   logic [7:0] ctxt  [9];
   logic [7:0] abc   [9];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int ML = (g == 0) ? 3 : ((g == 1) ? 9 : 300);
      localparam int CE = (g == 1) ? 1 : 0;
      localparam int KW = (ML > 1) ? $clog2(ML) : 1;

      logic [7:0]    s_addr, s_wdata, s_rdata, rom_rdata, res_wdata;
      logic [KW-1:0] rom_addr, res_addr;
      logic          res_wren;
      logic [7:0]    s_mem [256];
      int            e;

      rc4_prga_engine #(.MSG_LEN(ML), .CHECK_EN(CE)) u_dut (
         .clk       (clk),
         .reset_n   (rst_n),
         .start     (start[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .key_ok    (key_ok[g]),
         .s_addr    (s_addr),
         .s_wdata   (s_wdata),
         .s_wren    (s_wren[g]),
         .s_rdata   (s_rdata),
         .rom_addr  (rom_addr),
         .rom_rdata (rom_rdata),
         .res_addr  (res_addr),
         .res_wdata (res_wdata),
         .res_wren  (res_wren)
      );

      always @(posedge clk) begin
         if (ld[g]) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_img[g][x];
         end else if (s_wren[g]) begin
            s_mem[s_addr] <= s_wdata;
         end
         s_rdata <= s_mem[s_addr];
      end

      assign rom_rdata = rom_img[g][rom_addr];

      always @(negedge clk) begin
         if (res_wren) begin
            checks++;
            if (exp_q[g].size() == 0) begin
               errors++;
               $display("FAIL d%0d_extra_write: got addr %0d data %02h, expected no write", g, res_addr, res_wdata);
            end else begin
               e = exp_q[g].pop_front();
               if ((int'(res_addr) != e / 256) || (int'(res_wdata) != e % 256)) begin
                  errors++;
                  $display("FAIL d%0d_result: got addr %0d data %02h, expected addr %0d data %02h",
                           g, res_addr, res_wdata, e / 256, e % 256);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int g, input int addr, input int data);
      exp_q[g].push_back(addr * 256 + data);
   endtask

   task automatic identity_img(input int g);
      for (int x = 0; x < 256; x++) s_img[g][x] = 8'(x);
   endtask

   task automatic load_s(input int g);
      @(negedge clk);
      ld[g] = 1'b1;
      @(negedge clk);
      ld[g] = 1'b0;
   endtask

   // Software RC4 key schedule into ms
   task automatic ksa();
      logic [7:0] j, t;
      for (int x = 0; x < 256; x++) ms[x] = 8'(x);
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         j = j + ms[x] + key_b[x % 3];
         t = ms[x]; ms[x] = ms[j]; ms[j] = t;
      end
   endtask

   task automatic model_prga(input int n);
      logic [7:0] i, j, t;
      i = 8'd0;
      j = 8'd0;
      for (int k = 0; k < n; k++) begin
         i = i + 8'd1;
         j = j + ms[i];
         t = ms[i]; ms[i] = ms[j]; ms[j] = t;
         ks[k] = ms[8'(ms[i] + ms[j])];
      end
   endtask

   task automatic run(input int g, input int n, input bit ok, input bit hold);
      int ts;
      bit seen;
      @(negedge clk);
      start[g] = 1'b1;
      ts = cyc + 1;
      seen = 1'b0;
      for (int c = 0; c < 11 * n + 40; c++) begin
         @(negedge clk);
         if (c == 0) chk($sformatf("d%0d_busy_rise", g), int'(busy[g]), 1);
         if (done[g]) begin
            seen = 1'b1;
            break;
         end
      end
      chk($sformatf("d%0d_done_seen", g), int'(seen), 1);
      chk($sformatf("d%0d_done_latency", g), cyc - ts, 11 * n);
      chk($sformatf("d%0d_key_ok", g), int'(key_ok[g]), int'(ok));
      chk($sformatf("d%0d_writes_drained", g), exp_q[g].size(), 0);
      if (hold) begin
         repeat (5) @(negedge clk);
         chk("hold_done", int'(done[g]), 1);
         chk("hold_busy", int'(busy[g]), 0);
      end
      start[g] = 1'b0;
      if (hold) begin
         @(negedge clk);
         chk("release_done", int'(done[g]), 0);
         chk("release_busy", int'(busy[g]), 0);
      end
   endtask

   initial begin
      int hit;
      for (int g = 0; g < 3; g++) begin
         start[g] = 1'b0;
         ld[g]    = 1'b0;
         for (int x = 0; x < 300; x++) rom_img[g][x] = 8'h00;
         identity_img(g);
      end
      key_b = '{8'h4B, 8'h65, 8'h79};
      ptxt  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      ctxt  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      abc   = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_done", int'(done[0]), 0);
      chk("rst_key_ok", int'(key_ok[0]), 0);
      chk("rst_s_wren", int'(s_wren[0]), 0);
      chk("rst_res_wren", int'(g_dut[0].res_wren), 0);
      chk("rst_s_addr", int'(g_dut[0].s_addr), 0);
      chk("rst_res_addr", int'(g_dut[2].res_addr), 0);
      rst_n = 1'b1;

      // Identity S, no screen, ROM zeros: pure keystream 02 05 07
      load_s(0);
      push(0, 0, 8'h02); push(0, 1, 8'h05); push(0, 2, 8'h07);
      run(0, 3, 1'b1, 1'b1);
      chk("s_end_2", int'(g_dut[0].s_mem[2]), 8'h03);
      chk("s_end_3", int'(g_dut[0].s_mem[3]), 8'h05);
      chk("s_end_5", int'(g_dut[0].s_mem[5]), 8'h02);

      // Second start after S rebuild must restart from i=1, j=0
      load_s(0);
      push(0, 0, 8'h02); push(0, 1, 8'h05); push(0, 2, 8'h07);
      run(0, 3, 1'b1, 1'b0);

      // Asynchronous reset while writing S at WR_J
      load_s(0);
      @(negedge clk);
      start[0] = 1'b1;
      hit = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_wren[0]) begin
            hit = 1;
            break;
         end
      end
      chk("reach_wr_j", hit, 1);
      rst_n    = 1'b0;
      start[0] = 1'b0;
      #1;
      chk("rst_mid_s_wren", int'(s_wren[0]), 0);
      chk("rst_mid_busy", int'(busy[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", int'(busy[0] | done[0]), 0);

      // Screened run decoding "abcdefghi" from identity S
      for (int x = 0; x < 256; x++) ms[x] = 8'(x);
      model_prga(9);
      rom_img[1][0] = 8'h63; rom_img[1][1] = 8'h67; rom_img[1][2] = 8'h64;
      for (int x = 3; x < 9; x++) rom_img[1][x] = ks[x] ^ abc[x];
      for (int x = 0; x < 9; x++) push(1, x, abc[x]);
      load_s(1);
      run(1, 9, 1'b1, 1'b0);

      // Screen rejects byte 0 (0x02) after writing it
      for (int x = 0; x < 9; x++) rom_img[1][x] = 8'h00;
      load_s(1);
      push(1, 0, 8'h02);
      run(1, 1, 1'b0, 1'b0);

      // Key "Key": 'P' is not lowercase, abort at byte 0
      ksa();
      for (int x = 0; x < 256; x++) s_img[1][x] = ms[x];
      for (int x = 0; x < 9; x++) rom_img[1][x] = ctxt[x];
      load_s(1);
      push(1, 0, 8'h50);
      run(1, 1, 1'b0, 1'b0);

      // Key "Key", unscreened 300-byte run: "Plaintext" then model keystream
      ksa();
      for (int x = 0; x < 256; x++) s_img[2][x] = ms[x];
      model_prga(300);
      for (int x = 0; x < 9; x++) rom_img[2][x] = ctxt[x];
      for (int x = 0; x < 9; x++) push(2, x, ptxt[x]);
      for (int x = 9; x < 300; x++) push(2, x, ks[x]);
      load_s(2);
      run(2, 300, 1'b1, 1'b0);

      // Identity S, 300 bytes with patterned ROM; i wraps past 255
      identity_img(2);
      for (int x = 0; x < 256; x++) ms[x] = 8'(x);
      model_prga(300);
      for (int x = 0; x < 300; x++) rom_img[2][x] = 8'((x * 7) + 3);
      push(2, 0, 8'h02 ^ 8'h03); push(2, 1, 8'h05 ^ 8'h0A); push(2, 2, 8'h07 ^ 8'h11);
      for (int x = 3; x < 300; x++) push(2, x, ks[x] ^ rom_img[2][x]);
      load_s(2);
      run(2, 300, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
